// File: rtl/vx_tcu_drl_nr_sched.sv
// Shares one norm/round datapath among NUM_REQS requesters; round-robin issue, in-order response FIFO.
// Latency: accept at edge T, response visible after edge T+1 (2 cycles valid-to-rsp_valid).
// Backpressure: grants are credit-gated by FIFO occupancy plus the in-flight issue; never by rsp_ready directly.

module vx_tcu_drl_nr_sched_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [DW-1:0]    push_dat,
    input  logic             pop,
    output logic [DW-1:0]    head_dat,
    output logic [CNT_W-1:0] count
);
    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module vx_tcu_drl_nr_sched #(
    parameter int NUM_REQS  = 4,
    parameter int N         = 5,
    parameter int W         = 53,
    parameter int TAG_W     = 4,
    parameter int OUT_DEPTH = 4,
    localparam int ACC_W  = W + $clog2(N) + 1,
    localparam int DATA_W = 8 + ACC_W + 7 + (N - 1) + 1 + 3,
    localparam int IDX_W  = $clog2(NUM_REQS),
    localparam int CNT_W  = $clog2(OUT_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQS-1:0]        req_valid,
    output logic [NUM_REQS-1:0]        req_ready,
    input  logic [NUM_REQS*DATA_W-1:0] req_data,
    input  logic [NUM_REQS*TAG_W-1:0]  req_tag,
    output logic [7:0]                 nr_max_exp,
    output logic [ACC_W-1:0]           nr_acc_sig,
    output logic [6:0]                 nr_hi_c,
    output logic [N-2:0]               nr_sig_signs,
    output logic                       nr_fmt_sel,
    output logic [2:0]                 nr_exceptions,
    input  logic [31:0]                nr_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_result,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [IDX_W-1:0]           rsp_idx
);
    localparam int RSP_W = 32 + TAG_W + IDX_W;

    logic              iss_valid;
    logic [DATA_W-1:0] iss_data;
    logic [TAG_W-1:0]  iss_tag;
    logic [IDX_W-1:0]  iss_idx;
    logic [IDX_W-1:0]  rr_ptr;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              credit;
    logic              grant_vld;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand;
    logic              grant;
    logic [DATA_W-1:0] sel_data;
    logic [TAG_W-1:0]  sel_tag;
    logic [RSP_W-1:0]  head_dat;

    // The issued-but-not-yet-pushed entry must be counted so a grant can never overflow the FIFO.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(iss_valid);
    assign credit    = occupancy < (CNT_W + 1)'(OUT_DEPTH);

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = rr_ptr + IDX_W'(k);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant     = grant_vld && credit && !reset;
    assign req_ready = grant ? (NUM_REQS'(1) << grant_idx) : '0;

    always_comb begin
        sel_data = '0;
        sel_tag  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_tag  = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_valid <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            iss_valid <= grant;
            if (grant) begin
                rr_ptr <= grant_idx + IDX_W'(1);
            end
        end
    end

    // Operand register holds its last value when idle; consumers ignore it then.
    always_ff @(posedge clk) begin
        if (grant) begin
            iss_data <= sel_data;
            iss_tag  <= sel_tag;
            iss_idx  <= grant_idx;
        end
    end

    assign {nr_max_exp, nr_acc_sig, nr_hi_c, nr_sig_signs, nr_fmt_sel, nr_exceptions} = iss_data;

    vx_tcu_drl_nr_sched_fifo #(
        .DW    (RSP_W),
        .DEPTH (OUT_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (iss_valid),
        .push_dat ({nr_result, iss_tag, iss_idx}),
        .pop      (rsp_valid && rsp_ready),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign rsp_valid = fifo_count != '0;
    assign {rsp_result, rsp_tag, rsp_idx} = head_dat;
endmodule

// File: tb/tb_vx_tcu_drl_nr_sched.sv
// Randomized bench for vx_tcu_drl_nr_sched with a queue-based reference model and a stand-in datapath.
module tb_vx_tcu_drl_nr_sched;
    localparam int NR     = 4;
    localparam int N      = 5;
    localparam int W      = 53;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 4;
    localparam int ACC_W  = W + $clog2(N) + 1;
    localparam int DATA_W = 8 + ACC_W + 7 + (N - 1) + 1 + 3;
    localparam int IDX_W  = $clog2(NR);
    localparam int NCYC   = 2000;
    localparam int RST_CYC = 1011;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NR-1:0]        req_valid = '0;
    logic [NR-1:0]        req_ready;
    logic [NR*DATA_W-1:0] req_data;
    logic [NR*TAG_W-1:0]  req_tag;
    logic [7:0]           nr_max_exp;
    logic [ACC_W-1:0]     nr_acc_sig;
    logic [6:0]           nr_hi_c;
    logic [N-2:0]         nr_sig_signs;
    logic                 nr_fmt_sel;
    logic [2:0]           nr_exceptions;
    logic [31:0]          nr_result;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [31:0]          rsp_result;
    logic [TAG_W-1:0]     rsp_tag;
    logic [IDX_W-1:0]     rsp_idx;

    logic [DATA_W-1:0] rdat [NR];
    logic [TAG_W-1:0]  rtag [NR];

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               idx;
    } rsp_t;

    rsp_t              exp_q[$];
    bit                iss_pend;
    rsp_t              iss_ent;
    logic [DATA_W-1:0] iss_dat;
    int                rr;
    int                n_chk;
    int                n_fail;
    int                g_thru;
    int                g_full;
    int                g_one;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NR; gi++) begin : g_pack
        assign req_data[gi*DATA_W +: DATA_W] = rdat[gi];
        assign req_tag[gi*TAG_W +: TAG_W]    = rtag[gi];
    end

    // Stand-in datapath: FP path packs sign/exp/mantissa, INT path adds hi_c/signs to the low accumulator bits.
    function automatic logic [31:0] dp_model(input logic [DATA_W-1:0] d);
        logic [7:0]       me;
        logic [ACC_W-1:0] acc;
        logic [6:0]       hi;
        logic [N-2:0]     sg;
        logic             fmt;
        logic [2:0]       exc;
        {me, acc, hi, sg, fmt, exc} = d;
        if (fmt) begin
            return acc[31:0] + 32'({hi, sg});
        end
        return {acc[ACC_W-1], me, acc[ACC_W-2 -: 23]} ^ {29'd0, exc};
    endfunction

    assign nr_result = dp_model({nr_max_exp, nr_acc_sig, nr_hi_c, nr_sig_signs, nr_fmt_sel, nr_exceptions});

    vx_tcu_drl_nr_sched #(
        .NUM_REQS  (NR),
        .N         (N),
        .W         (W),
        .TAG_W     (TAG_W),
        .OUT_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_tag       (req_tag),
        .nr_max_exp    (nr_max_exp),
        .nr_acc_sig    (nr_acc_sig),
        .nr_hi_c       (nr_hi_c),
        .nr_sig_signs  (nr_sig_signs),
        .nr_fmt_sel    (nr_fmt_sel),
        .nr_exceptions (nr_exceptions),
        .nr_result     (nr_result),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_tag       (rsp_tag),
        .rsp_idx       (rsp_idx)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int cyc);
        for (int i = 0; i < NR; i++) begin
            rdat[i] = DATA_W'({$urandom, $urandom, $urandom});
            rtag[i] = TAG_W'($urandom);
        end
        if (cyc == 0) begin
            req_valid = 4'b0001; rdat[0][3] = 1'b0; rtag[0] = 4'd5; rsp_ready = 1'b1;
        end else if (cyc < 6)   begin req_valid = 4'b0000; rsp_ready = 1'b1; end
        else if (cyc < 26)      begin req_valid = 4'b1111; rsp_ready = 1'b1; end
        else if (cyc < 34)      begin req_valid = 4'b0000; rsp_ready = 1'b1; end
        else if (cyc < 46)      begin req_valid = 4'b1111; rsp_ready = 1'b0; end
        else if (cyc == 46)     begin req_valid = 4'b1111; rsp_ready = 1'b1; end
        else if (cyc < 53)      begin req_valid = 4'b1111; rsp_ready = 1'b0; end
        else if (cyc < 63)      begin req_valid = 4'b1111; rsp_ready = 1'b1; end
        else if (cyc >= RST_CYC - 11 && cyc < RST_CYC - 3) begin
            req_valid = 4'b0000; rsp_ready = 1'b1;
        end else if (cyc >= RST_CYC - 3 && cyc <= RST_CYC) begin
            req_valid = 4'b1111; rsp_ready = 1'b0;
        end else begin
            req_valid = NR'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Checks the current cycle against the model, then advances the model across the coming edge.
    task automatic sample_and_update(output int g);
        int            exp_g;
        logic [NR-1:0] exp_rdy;
        exp_g   = -1;
        exp_rdy = '0;
        if (exp_q.size() + int'(iss_pend) < DEPTH) begin
            for (int k = 0; k < NR; k++) begin
                if (exp_g < 0 && req_valid[(rr + k) % NR]) exp_g = (rr + k) % NR;
            end
        end
        if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
        chk("req_ready", 128'(req_ready), 128'(exp_rdy));
        chk("rsp_valid", 128'(rsp_valid), 128'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("rsp_result", 128'(rsp_result), 128'(exp_q[0].res));
            chk("rsp_tag", 128'(rsp_tag), 128'(exp_q[0].tag));
            chk("rsp_idx", 128'(rsp_idx), 128'(exp_q[0].idx));
        end
        if (iss_pend) begin
            chk("nr_ops", 128'({nr_max_exp, nr_acc_sig, nr_hi_c, nr_sig_signs, nr_fmt_sel, nr_exceptions}),
                128'(iss_dat));
        end
        if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
        if (iss_pend) exp_q.push_back(iss_ent);
        iss_pend = (exp_g >= 0);
        if (exp_g >= 0) begin
            iss_dat     = rdat[exp_g];
            iss_ent.res = dp_model(rdat[exp_g]);
            iss_ent.tag = rtag[exp_g];
            iss_ent.idx = exp_g;
            rr          = (exp_g + 1) % NR;
        end
        g = exp_g;
    endtask

    initial begin
        int g;
        n_chk = 0; n_fail = 0; g_thru = 0; g_full = 0; g_one = 0;
        rr = 0; iss_pend = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rdat[i] = '0;
            rtag[i] = '0;
        end
        req_valid = 4'b1111;
        #1 reset = 1'b1;
        #1;
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        repeat (2) @(posedge clk);
        req_valid = '0;
        #1 reset = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            drive(cyc);
            if (cyc == RST_CYC) begin
                reset = 1'b1;
                #1;
                chk("midrst_rsp_valid", 128'(rsp_valid), 128'(0));
                chk("midrst_req_ready", 128'(req_ready), 128'(0));
                exp_q.delete();
                iss_pend = 1'b0;
                rr = 0;
                @(posedge clk);
                #1 reset = 1'b0;
            end
            #3;
            if (cyc == RST_CYC) chk("post_rst_grant", 128'(req_ready), 128'(4'b0001));
            sample_and_update(g);
            if (cyc >= 6 && cyc < 26 && req_ready != '0) g_thru++;
            if (cyc >= 34 && cyc < 46 && req_ready != '0) g_full++;
            if (cyc >= 46 && cyc < 53 && req_ready != '0) g_one++;
            if (cyc == 25) chk("throughput_grants", 128'(g_thru), 128'(20));
            if (cyc == 45) chk("full_grants", 128'(g_full), 128'(DEPTH));
            if (cyc == 52) chk("one_pop_one_grant", 128'(g_one), 128'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
